bp_update_ctrl: RTL and testbench
=================================

// Module: bp_update_ctrl
// PURPOSE
//  Update-side partner of tage_predictor: records every prediction issued to the front end and returns
//  resolved outcomes to the predictor's training port (br_result/correct/update_en/idx/domain/targ).
//  In-order FIFO of in-flight branches; the head is retired when the back end resolves the oldest branch.
//  Sits between the execute-stage branch unit and the predictor.
// PARAMETERS
//  DEPTH   8   in-flight branch entries; power of two, >=2
//  IDX_W   32  branch index (PC) width
//  TARG_W  32  branch target width
// PORTS
//  clk_i          in   1       clock
//  rst_ni         in   1       asynchronous, active-low reset
//  pred_valid_i   in   1       allocate entry for a newly issued prediction
//  pred_ready_o   out  1       entry available (count_o < DEPTH)
//  pred_idx_i     in   IDX_W   predicted branch index
//  pred_taken_i   in   1       predicted direction
//  pred_targ_i    in   TARG_W  predicted target
//  pred_domain_i  in   domain_t  security domain of the prediction
//  res_valid_i    in   1       oldest in-flight branch resolved
//  res_taken_i    in   1       actual direction
//  res_targ_i     in   TARG_W  actual target (valid when res_taken_i)
//  flush_i        in   1       squash all in-flight entries
//  update_en_o    out  1       one-cycle training strobe to predictor
//  idx_o          out  IDX_W   index of retired branch
//  br_result_o    out  1       actual direction of retired branch
//  correct_o      out  1       prediction was correct
//  domain_o       out  domain_t  domain of retired branch
//  targ_o         out  TARG_W  actual target of retired branch
//  count_o        out  $clog2(DEPTH)+1  current occupancy
//  err_o          out  1       sticky: resolution received while empty
// BEHAVIOUR
//  - Reset: queue empty, count_o=0, pred_ready_o=1, all data outputs 0, update_en_o=0, err_o=0.
//  - Allocate on pred_valid_i && pred_ready_o; pred_valid_i while !pred_ready_o is dropped (no stall).
//  - pred_ready_o depends on occupancy only: full rejects allocation even if a resolve occurs same cycle.
//  - Resolve: res_valid_i with count>0 pops head; outputs registered, update_en_o high exactly the next
//    cycle (latency 1). Outputs hold last values while update_en_o=0.
//  - correct_o = (pred_taken==res_taken_i) && (!res_taken_i || pred_targ==res_targ_i).
//  - res_valid_i with count=0: no update, err_o set until reset. No same-cycle alloc->resolve bypass:
//    an entry allocated in cycle N is resolvable from cycle N+1.
//  - Simultaneous alloc+resolve (not full, not empty): count unchanged, both take effect.
//  - flush_i: head resolve in the same cycle still retires and emits its update; then all entries
//    cleared, count_o=0 next cycle; an allocation in the flush cycle is discarded.
//  - Pointers wrap modulo DEPTH; count_o never exceeds DEPTH.
//  - Reset asserted mid-operation clears queue and suppresses any pending update strobe.
// CONFIGURATION
//  BP_UPD_STATS_EN defined: adds outputs retired_cnt_o[31:0], mispred_cnt_o[31:0]; increment on each
//  update_en_o (mispred when !correct_o), saturate at 32'hFFFF_FFFF, cleared by reset only.
//  Not defined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Shared package bp_pkg: bp_entry_t {idx, taken, targ, domain}, BP_UPD_DEPTH default; domain_t
//  remains in common defines. Sub-module bp_inflight_fifo (storage, pointers, count, flush);
//  bp_update_ctrl holds compare logic, output registers, err and stats.
// TESTING
//  1 Alloc idx=0x40 taken targ=0x100; resolve taken targ=0x100 -> next cycle update_en_o=1, idx_o=0x40,
//    br_result_o=1, correct_o=1.
//  2 Alloc not-taken; resolve taken targ=0x200 -> correct_o=0, br_result_o=1, targ_o=0x200.
//  3 Fill 8 entries -> pred_ready_o=0, 9th dropped; resolve+alloc same cycle -> alloc dropped, count_o=7.
//  4 Resolve on empty -> no update_en_o, err_o=1 and stays 1 across later traffic.
//  5 3 entries, flush_i with res_valid_i -> one update for head, count_o=0 next cycle.
//  6 Wrap: 20 alloc/resolve pairs at DEPTH=8 -> updates in order, idx_o matches each alloc.

Source files
------------

// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and defaults for the branch-predictor update path
package bp_pkg;

  // Security domain of a prediction, shared with the predictor side.
  typedef logic [1:0] domain_t;

  localparam int BP_UPD_DEPTH = 8;
  localparam int BP_IDX_W     = 32;
  localparam int BP_TARG_W    = 32;

  typedef struct packed {
    logic [BP_IDX_W-1:0]  idx;
    logic                 taken;
    logic [BP_TARG_W-1:0] targ;
    domain_t              domain;
  } bp_entry_t;

endpackage

// File: rtl/bp_update_ctrl_if.sv
// rtl/bp_update_ctrl_if.sv - prediction/resolve/training bundle for bp_update_ctrl
// Optional stats outputs present when BP_UPD_STATS_EN is defined.
interface bp_update_ctrl_if #(
  parameter int DEPTH  = bp_pkg::BP_UPD_DEPTH,
  parameter int IDX_W  = bp_pkg::BP_IDX_W,
  parameter int TARG_W = bp_pkg::BP_TARG_W
);
  import bp_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              pred_valid_i;
  logic              pred_ready_o;
  logic [IDX_W-1:0]  pred_idx_i;
  logic              pred_taken_i;
  logic [TARG_W-1:0] pred_targ_i;
  domain_t           pred_domain_i;
  logic              res_valid_i;
  logic              res_taken_i;
  logic [TARG_W-1:0] res_targ_i;
  logic              flush_i;
  logic              update_en_o;
  logic [IDX_W-1:0]  idx_o;
  logic              br_result_o;
  logic              correct_o;
  domain_t           domain_o;
  logic [TARG_W-1:0] targ_o;
  logic [CNT_W-1:0]  count_o;
  logic              err_o;
`ifdef BP_UPD_STATS_EN
  logic [31:0]       retired_cnt_o;
  logic [31:0]       mispred_cnt_o;
`endif

  modport master (
    output pred_valid_i, pred_idx_i, pred_taken_i, pred_targ_i, pred_domain_i,
    output res_valid_i, res_taken_i, res_targ_i, flush_i,
    input  pred_ready_o, update_en_o, idx_o, br_result_o, correct_o, domain_o,
    input  targ_o, count_o, err_o
`ifdef BP_UPD_STATS_EN
    , input retired_cnt_o, mispred_cnt_o
`endif
  );

  modport slave (
    input  pred_valid_i, pred_idx_i, pred_taken_i, pred_targ_i, pred_domain_i,
    input  res_valid_i, res_taken_i, res_targ_i, flush_i,
    output pred_ready_o, update_en_o, idx_o, br_result_o, correct_o, domain_o,
    output targ_o, count_o, err_o
`ifdef BP_UPD_STATS_EN
    , output retired_cnt_o, mispred_cnt_o
`endif
  );

endinterface

// File: rtl/bp_inflight_fifo.sv
// rtl/bp_inflight_fifo.sv - in-order storage of in-flight branches with flush
module bp_inflight_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  // Readiness is a function of occupancy only, so a same-cycle pop never frees a slot for a push.
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o && !flush_i;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/bp_update_ctrl.sv
// rtl/bp_update_ctrl.sv - retires resolved branches in order and drives predictor training
// Retired/mispredict counters present when BP_UPD_STATS_EN is defined.
module bp_update_ctrl
  import bp_pkg::*;
#(
  parameter int DEPTH  = BP_UPD_DEPTH,
  parameter int IDX_W  = BP_IDX_W,
  parameter int TARG_W = BP_TARG_W
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  bp_update_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic              taken;
    logic [TARG_W-1:0] targ;
    domain_t           domain;
  } entry_t;

  entry_t           wr_entry, head;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             fire, correct;

  logic              update_en_q, update_en_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              br_result_q, br_result_d;
  logic              correct_q, correct_d;
  domain_t           domain_q, domain_d;
  logic [TARG_W-1:0] targ_q, targ_d;
  logic              err_q, err_d;

  assign wr_entry = '{idx: bus.pred_idx_i, taken: bus.pred_taken_i,
                      targ: bus.pred_targ_i, domain: bus.pred_domain_i};

  bp_inflight_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (bus.pred_valid_i),
    .pop_i   (bus.res_valid_i),
    .flush_i (bus.flush_i),
    .wdata_i (wr_entry),
    .rdata_o (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Target only matters for a taken branch; a not-taken match is correct whatever the targets.
  assign fire    = bus.res_valid_i && !fifo_empty;
  assign correct = (head.taken == bus.res_taken_i) &&
                   (!bus.res_taken_i || (head.targ == bus.res_targ_i));

  always_comb begin
    update_en_d = fire;
    idx_d       = idx_q;
    br_result_d = br_result_q;
    correct_d   = correct_q;
    domain_d    = domain_q;
    targ_d      = targ_q;
    err_d       = err_q | (bus.res_valid_i & fifo_empty);
    if (fire) begin
      idx_d       = head.idx;
      br_result_d = bus.res_taken_i;
      correct_d   = correct;
      domain_d    = head.domain;
      targ_d      = bus.res_targ_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      update_en_q <= 1'b0;
      idx_q       <= '0;
      br_result_q <= 1'b0;
      correct_q   <= 1'b0;
      domain_q    <= '0;
      targ_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      update_en_q <= update_en_d;
      idx_q       <= idx_d;
      br_result_q <= br_result_d;
      correct_q   <= correct_d;
      domain_q    <= domain_d;
      targ_q      <= targ_d;
      err_q       <= err_d;
    end
  end

  assign bus.pred_ready_o = !fifo_full;
  assign bus.update_en_o  = update_en_q;
  assign bus.idx_o        = idx_q;
  assign bus.br_result_o  = br_result_q;
  assign bus.correct_o    = correct_q;
  assign bus.domain_o     = domain_q;
  assign bus.targ_o       = targ_q;
  assign bus.count_o      = fifo_count;
  assign bus.err_o        = err_q;

`ifdef BP_UPD_STATS_EN
  logic [31:0] retired_cnt_q, retired_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  // Counted off the registered strobe so the stats agree exactly with what the predictor saw.
  always_comb begin
    retired_cnt_d = retired_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (update_en_q && (retired_cnt_q != 32'hFFFF_FFFF)) retired_cnt_d = retired_cnt_q + 32'd1;
    if (update_en_q && !correct_q && (mispred_cnt_q != 32'hFFFF_FFFF))
      mispred_cnt_d = mispred_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      retired_cnt_q <= '0;
      mispred_cnt_q <= '0;
    end else begin
      retired_cnt_q <= retired_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign bus.retired_cnt_o = retired_cnt_q;
  assign bus.mispred_cnt_o = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_bp_update_ctrl.sv
// tb/tb_bp_update_ctrl.sv - randomized self-checking bench for bp_update_ctrl (BP_UPD_STATS_EN optional)
module tb_bp_update_ctrl;
  import bp_pkg::*;

  localparam int DEPTH  = 8;
  localparam int IDX_W  = 32;
  localparam int TARG_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bp_update_ctrl_if #(.DEPTH(DEPTH), .IDX_W(IDX_W), .TARG_W(TARG_W)) bus ();

  bp_update_ctrl #(.DEPTH(DEPTH), .IDX_W(IDX_W), .TARG_W(TARG_W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: in-flight branches as a plain queue plus the last training record.
  bp_entry_t   q[$];
  logic        m_upd, m_res, m_cor, m_err;
  logic [31:0] m_idx, m_targ;
  domain_t     m_dom;
  logic [31:0] m_ret, m_mis;

  task automatic clear_inputs();
    bus.pred_valid_i  = 1'b0;
    bus.pred_idx_i    = '0;
    bus.pred_taken_i  = 1'b0;
    bus.pred_targ_i   = '0;
    bus.pred_domain_i = '0;
    bus.res_valid_i   = 1'b0;
    bus.res_taken_i   = 1'b0;
    bus.res_targ_i    = '0;
    bus.flush_i       = 1'b0;
  endtask

  task automatic model_reset();
    q.delete();
    m_upd = 0; m_res = 0; m_cor = 0; m_err = 0;
    m_idx = '0; m_targ = '0; m_dom = '0;
    m_ret = '0; m_mis = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input logic pv, input logic [31:0] pidx, input logic pt,
                      input logic [31:0] ptarg, input domain_t pd, input logic rv,
                      input logic rt, input logic [31:0] rtarg, input logic fl);
    bp_entry_t h;
    bit        had_room;
    @(negedge clk);
    bus.pred_valid_i  = pv;
    bus.pred_idx_i    = pidx;
    bus.pred_taken_i  = pt;
    bus.pred_targ_i   = ptarg;
    bus.pred_domain_i = pd;
    bus.res_valid_i   = rv;
    bus.res_taken_i   = rt;
    bus.res_targ_i    = rtarg;
    bus.flush_i       = fl;
    had_room = (q.size() < DEPTH);
    if (m_upd) begin
      if (m_ret != 32'hFFFF_FFFF) m_ret++;
      if (!m_cor && m_mis != 32'hFFFF_FFFF) m_mis++;
    end
    m_upd = 0;
    if (rv) begin
      if (q.size() != 0) begin
        h = q.pop_front();
        m_upd = 1;
        m_idx = h.idx;
        m_res = rt;
        m_cor = (h.taken == rt) && (!rt || h.targ == rtarg);
        m_dom = h.domain;
        m_targ = rtarg;
      end else begin
        m_err = 1;
      end
    end
    if (pv && had_room && !fl) begin
      h = '{idx: pidx, taken: pt, targ: ptarg, domain: pd};
      q.push_back(h);
    end
    if (fl) q.delete();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic alloc(input logic [31:0] idx, input logic t, input logic [31:0] targ, input domain_t d);
    step(1'b1, idx, t, targ, d, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic resolve(input logic t, input logic [31:0] targ);
    step(1'b0, '0, 1'b0, '0, '0, 1'b1, t, targ, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.count_o !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count_o); end
    checks++; if (bus.pred_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", bus.pred_ready_o); end
    checks++; if (bus.update_en_o !== 1'b0) begin failures++; $display("FAIL reset_upd got=%0b exp=0", bus.update_en_o); end
    checks++; if ({bus.idx_o, bus.targ_o, bus.br_result_o, bus.correct_o, bus.domain_o} !== '0) begin
      failures++; $display("FAIL reset_data got idx=%h targ=%h exp all 0", bus.idx_o, bus.targ_o); end
    checks++; if (bus.err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", bus.err_o); end
    release_reset();
  endtask

  task automatic test_basic();
    alloc(32'h40, 1'b1, 32'h100, 2'd1);
    checks++; if (bus.count_o !== 4'd1) begin failures++; $display("FAIL t1_count got=%0d exp=1", bus.count_o); end
    checks++; if (bus.update_en_o !== 1'b0) begin failures++; $display("FAIL t1_noupd got=%0b exp=0", bus.update_en_o); end
    resolve(1'b1, 32'h100);
    checks++; if (bus.update_en_o !== 1'b1) begin failures++; $display("FAIL t1_upd got=%0b exp=1", bus.update_en_o); end
    checks++; if (bus.idx_o !== 32'h40) begin failures++; $display("FAIL t1_idx got=%h exp=40", bus.idx_o); end
    checks++; if (bus.br_result_o !== 1'b1 || bus.correct_o !== 1'b1) begin
      failures++; $display("FAIL t1_result got br=%0b cor=%0b exp br=1 cor=1", bus.br_result_o, bus.correct_o); end
    checks++; if (bus.domain_o !== 2'd1) begin failures++; $display("FAIL t1_domain got=%0d exp=1", bus.domain_o); end
    idle();
    checks++; if (bus.update_en_o !== 1'b0 || bus.idx_o !== 32'h40) begin
      failures++; $display("FAIL t1_hold got upd=%0b idx=%h exp upd=0 idx=40", bus.update_en_o, bus.idx_o); end
    alloc(32'h44, 1'b0, 32'h300, 2'd2);
    resolve(1'b1, 32'h200);
    checks++; if (bus.update_en_o !== 1'b1 || bus.correct_o !== 1'b0) begin
      failures++; $display("FAIL t2_cor got upd=%0b cor=%0b exp upd=1 cor=0", bus.update_en_o, bus.correct_o); end
    checks++; if (bus.br_result_o !== 1'b1 || bus.targ_o !== 32'h200) begin
      failures++; $display("FAIL t2_targ got br=%0b targ=%h exp br=1 targ=200", bus.br_result_o, bus.targ_o); end
    alloc(32'h48, 1'b1, 32'h500, 2'd0);
    resolve(1'b1, 32'h504);
    checks++; if (bus.correct_o !== 1'b0) begin failures++; $display("FAIL t2_wrong_targ got=%0b exp=0", bus.correct_o); end
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) alloc(32'h1000 + i, i[0], 32'h2000 + i, domain_t'(i));
    checks++; if (bus.pred_ready_o !== 1'b0 || bus.count_o !== 4'd8) begin
      failures++; $display("FAIL t3_full got ready=%0b count=%0d exp ready=0 count=8", bus.pred_ready_o, bus.count_o); end
    alloc(32'h9999, 1'b0, '0, '0);
    checks++; if (bus.count_o !== 4'd8) begin failures++; $display("FAIL t3_drop got=%0d exp=8", bus.count_o); end
    step(1'b1, 32'h3000, 1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b0);
    checks++; if (bus.count_o !== 4'd7 || bus.update_en_o !== 1'b1 || bus.idx_o !== 32'h1000) begin
      failures++; $display("FAIL t3_rsv_alloc got count=%0d upd=%0b idx=%h exp 7 1 1000", bus.count_o, bus.update_en_o, bus.idx_o); end
    for (int i = 1; i < DEPTH; i++) begin
      resolve(1'b0, '0);
      checks++; if (bus.idx_o !== 32'h1000 + i || bus.correct_o !== m_cor) begin
        failures++; $display("FAIL t3_drain%0d got idx=%h cor=%0b exp idx=%h cor=%0b", i, bus.idx_o, bus.correct_o, 32'h1000 + i, m_cor); end
    end
    checks++; if (bus.count_o !== 4'd0 || bus.pred_ready_o !== 1'b1) begin
      failures++; $display("FAIL t3_empty got count=%0d ready=%0b exp 0 1", bus.count_o, bus.pred_ready_o); end
  endtask

  task automatic test_empty_err();
    step(1'b1, 32'h77, 1'b1, 32'h88, 2'd3, 1'b1, 1'b1, 32'h88, 1'b0);
    checks++; if (bus.update_en_o !== 1'b0 || bus.err_o !== 1'b1) begin
      failures++; $display("FAIL t4_err got upd=%0b err=%0b exp upd=0 err=1", bus.update_en_o, bus.err_o); end
    checks++; if (bus.count_o !== 4'd1) begin failures++; $display("FAIL t4_nobypass got=%0d exp=1", bus.count_o); end
    resolve(1'b1, 32'h88);
    checks++; if (bus.update_en_o !== 1'b1 || bus.idx_o !== 32'h77 || bus.correct_o !== 1'b1) begin
      failures++; $display("FAIL t4_next got upd=%0b idx=%h cor=%0b exp 1 77 1", bus.update_en_o, bus.idx_o, bus.correct_o); end
    repeat (3) idle();
    checks++; if (bus.err_o !== 1'b1) begin failures++; $display("FAIL t4_sticky got=%0b exp=1", bus.err_o); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) alloc(32'h500 + i, 1'b1, 32'h50, 2'd2);
    step(1'b1, 32'h600, 1'b0, '0, '0, 1'b1, 1'b1, 32'h50, 1'b1);
    checks++; if (bus.update_en_o !== 1'b1 || bus.idx_o !== 32'h500 || bus.correct_o !== 1'b1) begin
      failures++; $display("FAIL t5_head got upd=%0b idx=%h cor=%0b exp 1 500 1", bus.update_en_o, bus.idx_o, bus.correct_o); end
    checks++; if (bus.count_o !== 4'd0) begin failures++; $display("FAIL t5_count got=%0d exp=0", bus.count_o); end
    idle();
    checks++; if (bus.update_en_o !== 1'b0) begin failures++; $display("FAIL t5_single got=%0b exp=0", bus.update_en_o); end
    alloc(32'h700, 1'b0, '0, 2'd1);
    resolve(1'b0, '0);
    checks++; if (bus.idx_o !== 32'h700) begin failures++; $display("FAIL t5_after got=%h exp=700", bus.idx_o); end
  endtask

  task automatic test_reset_mid();
    alloc(32'hA0, 1'b1, 32'h10, '0);
    alloc(32'hA4, 1'b1, 32'h10, '0);
    @(negedge clk);
    bus.res_valid_i = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (bus.update_en_o !== 1'b0 || bus.count_o !== 4'd0 || bus.pred_ready_o !== 1'b1) begin
      failures++; $display("FAIL rst_mid got upd=%0b count=%0d ready=%0b exp 0 0 1", bus.update_en_o, bus.count_o, bus.pred_ready_o); end
    clear_inputs();
    model_reset();
    release_reset();
  endtask

  task automatic test_wrap();
    logic [31:0] idx, targ, rtarg;
    logic        t, rt;
    for (int i = 0; i < 20; i++) begin
      idx = $urandom; targ = $urandom_range(0, 3); t = $urandom_range(0, 1);
      rt = $urandom_range(0, 1); rtarg = $urandom_range(0, 3);
      alloc(idx, t, targ, domain_t'($urandom_range(0, 3)));
      resolve(rt, rtarg);
      checks++; if (bus.update_en_o !== 1'b1 || bus.idx_o !== idx) begin
        failures++; $display("FAIL t6_wrap%0d got upd=%0b idx=%h exp 1 %h", i, bus.update_en_o, bus.idx_o, idx); end
      checks++; if (bus.correct_o !== ((t == rt) && (!rt || targ == rtarg))) begin
        failures++; $display("FAIL t6_cor%0d got=%0b exp=%0b", i, bus.correct_o, (t == rt) && (!rt || targ == rtarg)); end
    end
  endtask

  task automatic test_random();
    logic        pv, rv, rt, fl;
    logic [31:0] rtarg;
    for (int i = 0; i < 400; i++) begin
      pv = ($urandom_range(0, 9) < 6);
      rv = ($urandom_range(0, 9) < 5);
      fl = ($urandom_range(0, 99) < 3);
      rt = $urandom_range(0, 1);
      rtarg = (q.size() != 0 && $urandom_range(0, 1)) ? q[0].targ : 32'($urandom_range(0, 7));
      step(pv, $urandom, $urandom_range(0, 1), 32'($urandom_range(0, 7)), domain_t'($urandom_range(0, 3)),
           rv, rt, rtarg, fl);
      checks++; if (bus.update_en_o !== m_upd || bus.count_o !== q.size() || bus.err_o !== m_err) begin
        failures++; $display("FAIL rnd%0d_ctl got upd=%0b cnt=%0d err=%0b exp %0b %0d %0b",
                             i, bus.update_en_o, bus.count_o, bus.err_o, m_upd, q.size(), m_err); end
      checks++; if (bus.pred_ready_o !== (q.size() < DEPTH)) begin
        failures++; $display("FAIL rnd%0d_ready got=%0b exp=%0b", i, bus.pred_ready_o, q.size() < DEPTH); end
      checks++; if (bus.idx_o !== m_idx || bus.targ_o !== m_targ || bus.domain_o !== m_dom ||
                    bus.br_result_o !== m_res || bus.correct_o !== m_cor) begin
        failures++; $display("FAIL rnd%0d_data got idx=%h targ=%h dom=%0d br=%0b cor=%0b exp %h %h %0d %0b %0b",
                             i, bus.idx_o, bus.targ_o, bus.domain_o, bus.br_result_o, bus.correct_o,
                             m_idx, m_targ, m_dom, m_res, m_cor); end
`ifdef BP_UPD_STATS_EN
      checks++; if (bus.retired_cnt_o !== m_ret || bus.mispred_cnt_o !== m_mis) begin
        failures++; $display("FAIL rnd%0d_stats got ret=%0d mis=%0d exp %0d %0d",
                             i, bus.retired_cnt_o, bus.mispred_cnt_o, m_ret, m_mis); end
`endif
    end
  endtask

  initial begin
    clear_inputs();
    model_reset();
    test_reset();
    test_basic();
    test_full();
    test_empty_err();
    do_reset();
    release_reset();
    test_flush();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
